// File: rtl/serial_image_loader.sv
// Serial image loader: receives a framed byte stream (sync, big-endian
// width/height header, then width*height pixel bytes) and writes the pixels
// into a byte-wide memory.
module serial_image_loader #(
    parameter int unsigned MAX_PIXELS     = 65536,
    parameter int unsigned TIMEOUT_CYCLES = 24000000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic        clk_24,
    input  logic        reset_n,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic [15:0] img_width,
    output logic [15:0] img_height,
    output logic        busy,
    output logic        frame_done,
    output logic        error
);

    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_W_HI   = 3'd1;
    localparam logic [2:0] S_W_LO   = 3'd2;
    localparam logic [2:0] S_H_HI   = 3'd3;
    localparam logic [2:0] S_H_LO   = 3'd4;
    localparam logic [2:0] S_CHECK  = 3'd5;
    localparam logic [2:0] S_PIXELS = 3'd6;

    logic            sync1, sync2, sync_prev;
    logic [2:0]      state, state_d;
    logic [7:0]      byte_q;
    logic [15:0]     width_q, width_d;
    logic [15:0]     height_q, height_d;
    logic [15:0]     pix_cnt, pix_cnt_d;
    logic [31:0]     pix_last, pix_last_d;
    logic [TO_W-1:0] to_cnt, to_cnt_d;
    logic            mem_we_d, frame_done_d, error_d, busy_d;
    logic [15:0]     mem_addr_d, img_width_d, img_height_d;
    logic [7:0]      mem_data_d;

    logic            accept_c;
    logic [7:0]      byte_c;
    logic [31:0]     product_c;
    logic            timeout_c;

    // Rising edge of the synchronized byte-valid marks one accepted byte.
    assign accept_c  = sync2 & ~sync_prev;
    // Holding register loads in the accept cycle; logic sees the new byte immediately.
    assign byte_c    = accept_c ? rx_data : byte_q;
    assign product_c = 32'(width_q) * 32'(height_q);
    // A byte arriving in the expiry cycle wins over the timeout.
    assign timeout_c = (state != S_IDLE) && !accept_c &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Synchronizer, delay flop and byte holding register.
    always_ff @(posedge clk_24 or negedge reset_n) begin
        if (!reset_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
            byte_q    <= 8'd0;
        end else begin
            sync1     <= rx_ready;
            sync2     <= sync1;
            sync_prev <= sync2;
            byte_q    <= byte_c;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk_24 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            width_q    <= 16'd0;
            height_q   <= 16'd0;
            pix_cnt    <= 16'd0;
            pix_last   <= 32'd0;
            to_cnt     <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= 16'd0;
            mem_data   <= 8'd0;
            img_width  <= 16'd0;
            img_height <= 16'd0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_d;
            width_q    <= width_d;
            height_q   <= height_d;
            pix_cnt    <= pix_cnt_d;
            pix_last   <= pix_last_d;
            to_cnt     <= to_cnt_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_data   <= mem_data_d;
            img_width  <= img_width_d;
            img_height <= img_height_d;
            busy       <= busy_d;
            frame_done <= frame_done_d;
            error      <= error_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d      = state;
        width_d      = width_q;
        height_d     = height_q;
        pix_cnt_d    = pix_cnt;
        pix_last_d   = pix_last;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr;
        mem_data_d   = mem_data;
        img_width_d  = img_width;
        img_height_d = img_height;
        frame_done_d = 1'b0;
        error_d      = error;
        to_cnt_d     = (state == S_IDLE || accept_c) ? '0 : TO_W'(to_cnt + 1'b1);

        case (state)
            S_IDLE: begin
                if (accept_c && byte_c == SYNC_BYTE) begin
                    error_d = 1'b0;
                    state_d = S_W_HI;
                end
            end
            S_W_HI: begin
                if (accept_c) begin
                    width_d[15:8] = byte_c;
                    state_d       = S_W_LO;
                end
            end
            S_W_LO: begin
                if (accept_c) begin
                    width_d[7:0] = byte_c;
                    state_d      = S_H_HI;
                end
            end
            S_H_HI: begin
                if (accept_c) begin
                    height_d[15:8] = byte_c;
                    state_d        = S_H_LO;
                end
            end
            S_H_LO: begin
                if (accept_c) begin
                    height_d[7:0] = byte_c;
                    state_d       = S_CHECK;
                end
            end
            S_CHECK: begin
                if (product_c == 32'd0 || product_c > 32'(MAX_PIXELS)) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    img_width_d  = width_q;
                    img_height_d = height_q;
                    pix_cnt_d    = 16'd0;
                    pix_last_d   = product_c - 32'd1;
                    state_d      = S_PIXELS;
                end
            end
            S_PIXELS: begin
                if (accept_c) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = pix_cnt;
                    mem_data_d = byte_c;
                    if (32'(pix_cnt) == pix_last) begin
                        frame_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        pix_cnt_d = 16'(pix_cnt + 16'd1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (timeout_c) begin
            error_d = 1'b1;
            state_d = S_IDLE;
        end

        busy_d = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_serial_image_loader.sv
// Self-checking bench for serial_image_loader: expected pixel writes are
// queued as bytes are sent and checked when mem_we fires.
module tb_serial_image_loader;

    logic        clk_24 = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic [15:0] img_width;
    logic [15:0] img_height;
    logic        busy;
    logic        frame_done;
    logic        error;

    int checks   = 0;
    int failures = 0;

    // Expected write: {frame_done, addr, data}
    logic [24:0] exp_q[$];

    serial_image_loader #(
        .MAX_PIXELS(65536),
        .TIMEOUT_CYCLES(1000),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk_24(clk_24),
        .reset_n(reset_n),
        .rx_ready(rx_ready),
        .rx_data(rx_data),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .img_width(img_width),
        .img_height(img_height),
        .busy(busy),
        .frame_done(frame_done),
        .error(error)
    );

    always #5 clk_24 = ~clk_24;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every write must match the head of the expected queue.
    always @(negedge clk_24) begin
        if (reset_n) begin
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_we", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    logic [24:0] e;
                    e = exp_q.pop_front();
                    check_val("wr_addr", 32'(mem_addr), 32'(e[23:8]));
                    check_val("wr_data", 32'(mem_data), 32'(e[7:0]));
                    check_val("wr_done", 32'(frame_done), 32'(e[24]));
                end
            end else if (frame_done) begin
                check_val("done_without_we", 32'(frame_done), 32'd0);
            end
        end
    end

    // One byte on the serial handshake; optionally checks the 3-edge write latency.
    task automatic send_byte(input logic [7:0] b, input bit chk_lat);
        @(negedge clk_24);
        rx_data  = b;
        rx_ready = 1'b1;
        repeat (2) @(posedge clk_24);
        #1;
        if (chk_lat) check_val("lat_edge2_we", 32'(mem_we), 32'd0);
        @(posedge clk_24);
        #1;
        if (chk_lat) check_val("lat_edge3_we", 32'(mem_we), 32'd1);
        repeat (2) @(posedge clk_24);
        @(negedge clk_24);
        rx_ready = 1'b0;
        repeat (4) @(negedge clk_24);
    endtask

    task automatic push_exp(input bit done, input logic [15:0] addr, input logic [7:0] data);
        exp_q.push_back({done, addr, data});
    endtask

    task automatic send_header(input logic [15:0] w, input logic [15:0] h);
        send_byte(8'hA5, 1'b0);
        send_byte(w[15:8], 1'b0);
        send_byte(w[7:0], 1'b0);
        send_byte(h[15:8], 1'b0);
        send_byte(h[7:0], 1'b0);
    endtask

    initial begin
        logic [7:0] px[4];
        px[0] = 8'h11; px[1] = 8'h22; px[2] = 8'h33; px[3] = 8'h44;

        // Reset state
        repeat (3) @(negedge clk_24);
        check_val("rst_outputs", {mem_we, busy, frame_done, error, 28'd0}, 32'd0);
        check_val("rst_addr_data", {mem_addr, mem_data, 8'd0}, 32'd0);
        check_val("rst_dims", {img_width, img_height}, 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_24);

        // 2x2 frame
        send_header(16'd2, 16'd2);
        check_val("busy_hdr", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            push_exp(i == 3, 16'(i), px[i]);
            send_byte(px[i], i == 0);
        end
        check_val("t1_width", 32'(img_width), 32'd2);
        check_val("t1_height", 32'(img_height), 32'd2);
        check_val("t1_busy", 32'(busy), 32'd0);
        check_val("t1_error", 32'(error), 32'd0);
        check_val("t1_drained", 32'(exp_q.size()), 32'd0);

        // Leading junk ignored, 1x1 frame
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        check_val("t2_busy_junk", 32'(busy), 32'd0);
        send_header(16'd1, 16'd1);
        push_exp(1'b1, 16'd0, 8'h7E);
        send_byte(8'h7E, 1'b1);
        check_val("t2_width", 32'(img_width), 32'd1);
        check_val("t2_drained", 32'(exp_q.size()), 32'd0);

        // Zero-area header
        send_header(16'd0, 16'd5);
        repeat (3) @(negedge clk_24);
        check_val("t3_error", 32'(error), 32'd1);
        check_val("t3_busy", 32'(busy), 32'd0);
        check_val("t3_dims_hold", {img_width, img_height}, {16'd1, 16'd1});
        send_byte(8'hA5, 1'b0);
        check_val("t3_error_clr", 32'(error), 32'd0);
        check_val("t3_busy_sync", 32'(busy), 32'd1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        push_exp(1'b1, 16'd0, 8'hA5);
        send_byte(8'hA5, 1'b1);
        check_val("t3_drained", 32'(exp_q.size()), 32'd0);

        // Oversized header (257*257)
        send_header(16'h0101, 16'h0101);
        repeat (3) @(negedge clk_24);
        check_val("t4_error", 32'(error), 32'd1);
        check_val("t4_busy", 32'(busy), 32'd0);
        check_val("t4_dims_hold", {img_width, img_height}, {16'd1, 16'd1});

        // Timeout after two pixels
        send_header(16'd2, 16'd2);
        check_val("t5_error_clr", 32'(error), 32'd0);
        push_exp(1'b0, 16'd0, 8'h01);
        send_byte(8'h01, 1'b0);
        push_exp(1'b0, 16'd1, 8'h02);
        send_byte(8'h02, 1'b0);
        check_val("t5_busy_pre", 32'(busy), 32'd1);
        repeat (1100) @(negedge clk_24);
        check_val("t5_error", 32'(error), 32'd1);
        check_val("t5_busy", 32'(busy), 32'd0);
        check_val("t5_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-frame, then a clean frame
        send_header(16'd2, 16'd2);
        push_exp(1'b0, 16'd0, 8'h0A);
        send_byte(8'h0A, 1'b0);
        push_exp(1'b0, 16'd1, 8'h0B);
        send_byte(8'h0B, 1'b0);
        @(negedge clk_24);
        reset_n = 1'b0;
        #1;
        check_val("t6_rst_flags", {mem_we, busy, frame_done, error, 28'd0}, 32'd0);
        check_val("t6_rst_addr_data", {mem_addr, mem_data, 8'd0}, 32'd0);
        check_val("t6_rst_dims", {img_width, img_height}, 32'd0);
        repeat (3) @(negedge clk_24);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_24);
        send_byte(8'h0C, 1'b0);
        check_val("t6_no_sync_busy", 32'(busy), 32'd0);
        send_header(16'd2, 16'd2);
        for (int i = 0; i < 4; i++) begin
            push_exp(i == 3, 16'(i), 8'(8'hC0 + i));
            send_byte(8'(8'hC0 + i), 1'b0);
        end
        check_val("t6_dims", {img_width, img_height}, {16'd2, 16'd2});
        check_val("t6_busy", 32'(busy), 32'd0);
        check_val("t6_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_image_loader.md
SERIAL_IMAGE_LOADER -- requirements
Module: serial_image_loader

Interface
REQ-001 SHALL have parameter MAX_PIXELS, default 65536, the largest accepted width*height product.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 24000000, the maximum clk_24 cycles allowed between accepted bytes while busy (1 s).
REQ-003 SHALL have parameter SYNC_BYTE, default 8'hA5, the frame start marker.
REQ-004 SHALL have port clk_24 input 1: the single 24 MHz clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n input 1: reset, asynchronous, active-low.
REQ-006 SHALL have port rx_ready input 1: level byte-valid from the serial receiver, high from stop bit until the next start bit, asynchronous to clk_24.
REQ-007 SHALL have port rx_data input 8: received byte, stable while rx_ready is high.
REQ-008 SHALL have port mem_we output 1: one-cycle pixel write strobe.
REQ-009 SHALL have port mem_addr output 16: pixel write address.
REQ-010 SHALL have port mem_data output 8: pixel write data.
REQ-011 SHALL have port img_width output 16: width of the last valid header.
REQ-012 SHALL have port img_height output 16: height of the last valid header.
REQ-013 SHALL have port busy output 1: high whenever state is not IDLE.
REQ-014 SHALL have port frame_done output 1: one-cycle pulse on frame completion.
REQ-015 SHALL have port error output 1: sticky frame-error flag.

Function
REQ-016 SHALL pass rx_ready through a 2-flop synchronizer plus a delay flop; a byte is accepted on each rising edge of the synchronized signal (sync2 & ~prev).
REQ-017 SHALL capture rx_data into a holding register in the same cycle the accept edge is detected.
REQ-018 SHALL implement states IDLE, W_HI, W_LO, H_HI, H_LO, CHECK, PIXELS.
REQ-019 SHALL, in IDLE, discard accepted bytes not equal to SYNC_BYTE; on SYNC_BYTE, clear error and go to W_HI.
REQ-020 SHALL load width big-endian in W_HI then W_LO, and height in H_HI then H_LO, advancing one state per accepted byte.
REQ-021 SHALL, in CHECK (one cycle), compute the 32-bit product width*height; if it is 0 or greater than MAX_PIXELS, set error and go to IDLE; otherwise clear the pixel counter and go to PIXELS.
REQ-022 SHALL update img_width/img_height only upon a header passing CHECK; otherwise they hold their previous values.
REQ-023 SHALL, in PIXELS, per accepted byte, assert mem_we for exactly one cycle with mem_data = byte and mem_addr = pixel counter, then increment the counter.
REQ-024 SHALL place mem_we high in the cycle following the third clk_24 rising edge at which rx_ready is sampled high (fixed 3-edge latency).
REQ-025 SHALL, on the write of pixel index product-1, assert frame_done in the same cycle as that mem_we and go to IDLE.
REQ-026 SHALL keep mem_addr and mem_data holding their last values when mem_we is low.
REQ-027 SHALL count idle cycles in every non-IDLE state, reset the count on each accepted byte, and on reaching TIMEOUT_CYCLES set error and go to IDLE with no write.
REQ-028 SHALL, when an accept edge and timeout expiry coincide, process the byte and not time out.
REQ-029 SHALL treat a SYNC_BYTE value received in any state other than IDLE as ordinary header or pixel data.
REQ-030 SHALL hold error high from its setting until the next SYNC_BYTE is accepted in IDLE or reset.

Reset
REQ-031 SHALL, while reset_n is low, force state IDLE, all synchronizer flops 0, counters 0, and mem_we, mem_addr, mem_data, img_width, img_height, busy, frame_done, error all 0.
REQ-032 SHALL, on reset mid-frame, abandon the frame with no further writes; after release, require a new SYNC_BYTE.
REQ-033 SHALL not detect an accept edge on the first cycle after reset release if rx_ready is already high, because the synchronizer and delay flops reset to 0.

Verification
REQ-034 Bytes A5,00,02,00,02,11,22,33,44 -> four mem_we pulses: addr 0..3 with data 11,22,33,44; frame_done with the 4th; img_width=2, img_height=2; busy low afterwards.
REQ-035 Bytes 00,FF,A5,00,01,00,01,7E -> leading bytes ignored; one write addr 0 data 7E; frame_done.
REQ-036 Header A5,00,00,00,05 -> error=1, no mem_we, img_width/height unchanged; next A5 clears error.
REQ-037 Header A5,01,01,01,01 (66049 > MAX_PIXELS) -> error=1, no writes.
REQ-038 Header 2x2 plus 2 pixels, then TIMEOUT_CYCLES silence (TIMEOUT_CYCLES=1000 for sim) -> error=1, busy=0, no frame_done.
REQ-039 reset_n low after the 2nd pixel of a 2x2 frame -> all outputs 0; subsequent complete frame writes from addr 0.
